fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
// - Parametrised single-clock synchronous FIFO; next generation of the fixed 16-bit buffer.
// - Adds configurable width/depth, fill level, programmable almost-full/almost-empty, overflow/underflow pulses.
// - Sits between producer/consumer blocks in the same clock domain; drop-in for the old port names.
// PARAMETERS
// - DATA_W    16  data word width in bits
// - DEPTH     8   number of entries; power of 2, >= 2
// - AF_LEVEL  6   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL  2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// - Localparam ADDR_W = $clog2(DEPTH).
// PORTS
// - clk           in   1           clock, all logic on rising edge
// - rst           in   1           synchronous reset, active-high
// - w_en          in   1           write request
// - data_in       in   DATA_W      write data, sampled when write accepted
// - r_en          in   1           read request
// - data_out      out  DATA_W      read data
// - empty         out  1           count == 0
// - full          out  1           count == DEPTH
// - almost_empty  out  1           count <= AE_LEVEL
// - almost_full   out  1           count >= AF_LEVEL
// - count         out  ADDR_W+1    current occupancy, 0..DEPTH
// - overflow      out  1           1-cycle pulse: write rejected
// - underflow     out  1           1-cycle pulse: read rejected
// BEHAVIOUR
// - Reset (rst=1 at clk edge): pointers, count=0; data_out=0; empty=1, almost_empty=1; full=0, almost_full=0;
//   overflow=0, underflow=0. Storage RAM not cleared. Reset mid-operation discards all content and wins over w_en/r_en.
// - Pointers ADDR_W+1 bits; the extra MSB distinguishes full from empty; natural wrap at 2*DEPTH, no special case.
// - wr_ok = w_en & (~full | rd_ok); rd_ok = r_en & ~empty.
//   - Full with w_en & r_en: both accepted, count unchanged.
//   - Empty with w_en & r_en: write only; underflow pulses.
// - w_en & ~wr_ok -> overflow=1 next cycle, memory/pointers untouched.
// - r_en & ~rd_ok -> underflow=1 next cycle, data_out holds its previous value.
// - count: +1 write only, -1 read only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
// - All flags and count are registered; they reflect the state after the edge, with no combinational path from inputs.
// - Read latency (standard mode): data_out is registered; the word popped at edge N is valid after edge N and held until the next accepted read.
// - Order strictly first-in first-out; no data reorder or loss except rejected writes.
// CONFIGURATION
// - Macro FIFO_FWFT_EN (first-word fall-through).
//   - Defined: data_out always shows the head entry while empty=0, with no read latency; r_en acknowledges/pops it.
//     A word written into an empty FIFO appears on data_out one cycle after the write edge, with empty=0 that same cycle.
//     data_out is don't-care while empty=1; no write+read bypass when empty.
//   - Undefined: standard mode above, 1-cycle registered read.
// TESTING
// - Reset: hold rst 2 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0, overflow=underflow=0.
// - Fill/drain, DEPTH=8: write 1..8 -> count=8, full=1, almost_full from count=6; read 8 -> data_out 1..8 in order, empty=1.
// - Overflow/underflow: write 9th word when full -> overflow one cycle, count stays 8, 9th word never read;
//   r_en when empty -> underflow one cycle, data_out unchanged.
// - Simultaneous: full with w_en=r_en=1, data_in=16'hAAAA -> count stays 8, head popped, 16'hAAAA read last;
//   empty with both -> count=1, underflow=1.
// - Wrap: 20 interleaved write/read pairs with occupancy held at 3 -> pointer wrap occurs, data order preserved, flags stable.
// - Reset mid-op: rst at count=5 -> next cycle count=0, empty=1; subsequent write 16'd32 then read returns 16'd32.
//   Repeat all tests with FIFO_FWFT_EN defined, checking the head is visible with 0 read latency.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill level, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word fall-through; otherwise data_out is a registered 1-cycle read.
module fifo_sync_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     r_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_empty;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [ADDR_W:0]   w_count_nxt;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_rd_ok = r_en & ~r_empty;
    assign w_wr_ok = w_en & (~r_full | w_rd_ok);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ONE_C;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ONE_C;
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == DEPTH_C);
            r_almost_empty <= (w_count_nxt <= AE_C);
            r_almost_full  <= (w_count_nxt >= AF_C);
            r_overflow     <= w_en & ~w_wr_ok;
            r_underflow    <= r_en & ~w_rd_ok;
        end
    end

    // Storage is deliberately not reset; reset only has to block the write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_ok) begin
            r_data_out <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    assign data_out = r_data_out;
`endif

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: vector table plus queue scoreboard.
// Works in both standard and FIFO_FWFT_EN builds.
module tb_fifo_sync_param;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    fifo_sync_param #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        int            cnt;
        logic          of;
        logic          uf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout = '0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic w, input logic [DW-1:0] d, input logic r,
                                input int cnt, input logic of, input logic uf);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.cnt = cnt; v.of = of; v.uf = uf;
        vecs.push_back(v);
    endfunction

    task automatic check_state(input logic exp_of, input logic exp_uf);
        int n;
        n = model_q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("overflow", 32'(overflow), 32'(exp_of));
        check("underflow", 32'(underflow), 32'(exp_uf));
`ifdef FIFO_FWFT_EN
        if (n != 0) check("fwft_head", 32'(data_out), 32'(model_q[0]));
`else
        check("data_out", 32'(data_out), 32'(exp_dout));
`endif
    endtask

    // One clock of stimulus; the scoreboard is updated with what the FIFO should accept.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        w_en = w; data_in = d; r_en = r;
        rd_ok = r && (model_q.size() != 0);
        wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0;
        if (rd_ok) exp_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        check_state(w && !wr_ok, r && !rd_ok);
    endtask

    task automatic do_reset(input int cycles, input logic w_during);
        @(negedge clk);
        rst = 1'b1; w_en = w_during; data_in = 16'h7777;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0; w_en = 1'b0;
        model_q.delete();
        exp_dout = '0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
        check("rst_data_out", 32'(data_out), 32'd0);
`endif
    endtask

    initial begin
        // Fill, overflow, full simultaneous, drain, underflow, empty simultaneous.
        for (int i = 1; i <= 8; i++) add(1'b1, DW'(i), 1'b0, i, 1'b0, 1'b0);
        add(1'b1, 16'd9, 1'b0, 8, 1'b1, 1'b0);
        add(1'b1, 16'hAAAA, 1'b1, 8, 1'b0, 1'b0);
        for (int i = 7; i >= 1; i--) add(1'b0, 16'h0, 1'b1, i, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b1, 0, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b1, 0, 1'b0, 1'b1);
        add(1'b1, 16'h0055, 1'b1, 1, 1'b0, 1'b1);
        add(1'b0, 16'h0, 1'b1, 0, 1'b0, 1'b0);

        do_reset(2, 1'b0);

        foreach (vecs[i]) begin
            cycle(vecs[i].w, vecs[i].d, vecs[i].r);
            check("vec_count", 32'(count), 32'(vecs[i].cnt));
            check("vec_overflow", 32'(overflow), 32'(vecs[i].of));
            check("vec_underflow", 32'(underflow), 32'(vecs[i].uf));
        end

        // Occupancy held at 3 while pointers wrap several times.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1);
            check("wrap_count", 32'(count), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Reset at count 5 with a write pending; reset must win.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h100 + i), 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        do_reset(1, 1'b1);
        cycle(1'b1, 16'd32, 1'b0);
`ifdef FIFO_FWFT_EN
        check("post_rst_head", 32'(data_out), 32'd32);
`endif
        cycle(1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
        check("post_rst_read", 32'(data_out), 32'd32);
`endif
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
